control_unit: RTL
=================

# control_unit

Instruction sequencer for the 10-bit Blueberry-Pi datapath. It captures a 10-bit instruction on an Execute button edge, then steps through timesteps T0–T3, driving the one-hot register and bus control strobes. It produces the `Time` and `Done` signals consumed by the display/output stage, which shows `Time` on its timestep hex digit and `Done` on its LED.

## Interface
Parameters:
- `NREG`, 4, number of general registers R0..R3; fixes the `Reg_Out`/`Reg_Ld` width.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `Instr`  in  10  instruction word: [9:6] opcode, [5:4] unused, [3:2] Rx, [1:0] Ry.
- `Execute`  in  1  debounced Execute button, active-high level.
- `Ir`  out  10  captured instruction register.
- `Time`  out  2  current timestep 0..3.
- `Done`  out  1  high from instruction completion until the next accepted Execute.
- `Ext_Out`  out  1  drive `Instr` data onto Bus.
- `Reg_Out`  out  NREG  one-hot register-to-Bus enable.
- `Reg_Ld`  out  NREG  one-hot register load from Bus.
- `A_Ld`  out  1  ALU operand register A load.
- `G_Ld`  out  1  ALU result register G load.
- `G_Out`  out  1  drive G onto Bus.
- `Alu_Op`  out  2  00 ADD, 01 SUB, 10 NOT, 11 PASS.

## Operation
- Opcodes: LOAD=0 (Rx←Ext), MOV=1 (Rx←Ry), ADD=2 (Rx←Rx+Ry), SUB=3 (Rx←Rx−Ry), INV=4 (Rx←~Ry). All other opcodes are illegal.
- Execute edge: the rising edge of `Execute` is detected internally (registered previous value). An edge is accepted only when `Time`=0. Edges at any other time are dropped, not queued.
- **T0 (idle):** on an accepted edge, `Ir`←`Instr`, `Done`←0, advance to T1. All strobes are 0 in T0.
- **T1**, decoded from `Ir`:
  - LOAD: `Ext_Out`, `Reg_Ld`[Rx]; finish.
  - MOV: `Reg_Out`[Ry], `Reg_Ld`[Rx]; finish.
  - ADD/SUB: `Reg_Out`[Rx], `A_Ld`; go to T2.
  - INV: `Reg_Out`[Ry], `Alu_Op`=NOT, `G_Ld`; go to T2.
  - Illegal: no strobes; finish.
- **T2:**
  - ADD/SUB: `Reg_Out`[Ry], `Alu_Op`=ADD or SUB, `G_Ld`; go to T3.
  - INV: `G_Out`, `Reg_Ld`[Rx]; finish.
- **T3:** `G_Out`, `Reg_Ld`[Rx]; finish.
- Finish means `Done`←1 at the next edge and `Time`←0.
- Bus exclusivity: at most one of `Ext_Out`, `G_Out`, and any `Reg_Out` bit is high in any cycle. `Reg_Out` and `Reg_Ld` are each one-hot or zero.
- `Alu_Op` is PASS whenever it is not named above.

## Timing
- All strobes are Moore outputs, decoded combinationally from registered `Time` and `Ir`; they are glitch-free relative to `clk`.
- Latency from accepted Execute edge to `Done`:
  - LOAD, MOV, illegal: 2 cycles.
  - INV: 3 cycles.
  - ADD, SUB: 4 cycles.
- Reset values: `Time`=0, `Done`=0, `Ir`=0, all strobes 0, `Alu_Op`=PASS, edge-detect history=1. The history reset value means a button already held during reset does not fire.
- Reset mid-instruction: everything returns immediately to the reset values. The partially executed instruction is abandoned, and no `Reg_Ld` is issued afterwards.
- Execute held high indefinitely runs exactly one instruction.
- Execute rising in the same cycle that `Time` returns to 0: not accepted. Acceptance requires the edge to be seen while already in T0.

## Configuration
- `CTRL_EXEC_SYNC_EN`, defined: `Execute` passes through a two-flop synchronizer, reset to 1, before edge detection. This adds 2 cycles to accept latency.
- Not defined: `Execute` feeds the edge detector directly; the input is assumed synchronous.

## Structure
- Shared package `blueberry_pkg` holds:
  - opcode enum (`OP_LOAD`..`OP_INV`);
  - `alu_op_t` enum;
  - `timestep_t` (T0..T3);
  - field-position constants for `Instr`.
- The output stage and ALU import the same `alu_op_t`.
- One sub-module, `exec_edge`: the optional synchronizer plus rising-edge detector, emitting a single-cycle `exec_pulse`.

## Test plan
- Reset: assert `rst` while `Execute`=1, then release → `Time`=0, `Done`=0, all strobes 0. The still-high `Execute` is not accepted.
- LOAD R2: `Instr`=10'b0000_00_10_00, pulse Execute → T1 shows `Ext_Out`=1, `Reg_Ld`=4'b0100. `Done`=1 two cycles after the accepted edge; `Time` back to 0.
- ADD R1,R3: `Instr`=10'b0010_00_01_11 → T1 `Reg_Out`=0010 with `A_Ld`; T2 `Reg_Out`=1000 with `G_Ld`, `Alu_Op`=00; T3 `G_Out` with `Reg_Ld`=0010; `Done` at cycle 4.
- Illegal opcode 4'b1111 → no strobes at any cycle, `Done`=1 after 2 cycles. A second Execute edge arriving during T1 is ignored.
- Reset at T2 of a SUB → `Time`=0 and `Reg_Ld`=0 on the same cycle; `Done` stays 0 with no later writeback.
- Bus exclusivity assertion held over 1000 random instructions and Execute timings; one-hot checks on `Reg_Out`/`Reg_Ld`.

Source files
------------

// File: rtl/blueberry_pkg.sv
// Shared types for the Blueberry-Pi datapath: opcodes, ALU operations,
// timesteps and instruction field positions.
package blueberry_pkg;

    typedef enum logic [3:0] {
        OP_LOAD = 4'd0,
        OP_MOV  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_INV  = 4'd4
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_NOT  = 2'b10,
        ALU_PASS = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } timestep_t;

    localparam int INSTR_W = 10;
    localparam int OPC_MSB = 9;
    localparam int OPC_LSB = 6;
    localparam int RX_MSB  = 3;
    localparam int RX_LSB  = 2;
    localparam int RY_MSB  = 1;
    localparam int RY_LSB  = 0;

    // Instructions that need the ALU take the long path through T2 (and T3).
    function automatic logic uses_alu(input logic [3:0] opc);
        return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_INV);
    endfunction

endpackage

// File: rtl/control_unit_exec_edge.sv
// Execute button rising-edge detector with optional two-flop synchronizer,
// enabled by defining CTRL_EXEC_SYNC_EN.
module exec_edge (
    input  logic clk,
    input  logic rst,
    input  logic exec_i,
    output logic exec_pulse_o
);

    logic exec_s;
    logic hist_q;

`ifdef CTRL_EXEC_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    // Reset to 1 so a button held through reset never looks like a new press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= exec_i;
            sync2_q <= sync1_q;
        end
    end

    assign exec_s = sync2_q;
`else
    assign exec_s = exec_i;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= exec_s;
        end
    end

    assign exec_pulse_o = exec_s & ~hist_q;

endmodule

// File: rtl/control_unit.sv
// Blueberry-Pi instruction sequencer: captures an instruction on an Execute
// press and steps T0..T3 issuing bus/register strobes. See CTRL_EXEC_SYNC_EN.
module control_unit
    import blueberry_pkg::*;
#(
    parameter int NREG = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INSTR_W-1:0]  Instr,
    input  logic                Execute,
    output logic [INSTR_W-1:0]  Ir,
    output logic [1:0]          Time,
    output logic                Done,
    output logic                Ext_Out,
    output logic [NREG-1:0]     Reg_Out,
    output logic [NREG-1:0]     Reg_Ld,
    output logic                A_Ld,
    output logic                G_Ld,
    output logic                G_Out,
    output logic [1:0]          Alu_Op
);

    timestep_t            time_q;
    logic [INSTR_W-1:0]   ir_q;
    logic                 done_q;
    logic                 exec_pulse;

    logic [3:0]           opc;
    logic [1:0]           rx;
    logic [1:0]           ry;
    logic [NREG-1:0]      rx_sel;
    logic [NREG-1:0]      ry_sel;
    alu_op_t              alu_op;

    exec_edge u_exec_edge (
        .clk          (clk),
        .rst          (rst),
        .exec_i       (Execute),
        .exec_pulse_o (exec_pulse)
    );

    assign opc    = ir_q[OPC_MSB:OPC_LSB];
    assign rx     = ir_q[RX_MSB:RX_LSB];
    assign ry     = ir_q[RY_MSB:RY_LSB];
    assign rx_sel = {{(NREG-1){1'b0}}, 1'b1} << rx;
    assign ry_sel = {{(NREG-1){1'b0}}, 1'b1} << ry;

    // Edges are only honoured while idle in T0; anything else is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_q <= T0;
            ir_q   <= '0;
            done_q <= 1'b0;
        end else begin
            case (time_q)
                T0: begin
                    if (exec_pulse) begin
                        ir_q   <= Instr;
                        done_q <= 1'b0;
                        time_q <= T1;
                    end
                end
                T1: begin
                    if (uses_alu(opc)) begin
                        time_q <= T2;
                    end else begin
                        time_q <= T0;
                        done_q <= 1'b1;
                    end
                end
                T2: begin
                    if ((opc == OP_ADD) || (opc == OP_SUB)) begin
                        time_q <= T3;
                    end else begin
                        time_q <= T0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    time_q <= T0;
                    done_q <= 1'b1;
                end
            endcase
        end
    end

    // Moore decode of the strobes from the registered timestep and instruction.
    always_comb begin
        Ext_Out = 1'b0;
        Reg_Out = '0;
        Reg_Ld  = '0;
        A_Ld    = 1'b0;
        G_Ld    = 1'b0;
        G_Out   = 1'b0;
        alu_op  = ALU_PASS;
        case (time_q)
            T1: begin
                case (opc)
                    OP_LOAD: begin
                        Ext_Out = 1'b1;
                        Reg_Ld  = rx_sel;
                    end
                    OP_MOV: begin
                        Reg_Out = ry_sel;
                        Reg_Ld  = rx_sel;
                    end
                    OP_ADD, OP_SUB: begin
                        Reg_Out = rx_sel;
                        A_Ld    = 1'b1;
                    end
                    OP_INV: begin
                        Reg_Out = ry_sel;
                        alu_op  = ALU_NOT;
                        G_Ld    = 1'b1;
                    end
                    default: ;
                endcase
            end
            T2: begin
                case (opc)
                    OP_ADD, OP_SUB: begin
                        Reg_Out = ry_sel;
                        alu_op  = (opc == OP_SUB) ? ALU_SUB : ALU_ADD;
                        G_Ld    = 1'b1;
                    end
                    OP_INV: begin
                        G_Out  = 1'b1;
                        Reg_Ld = rx_sel;
                    end
                    default: ;
                endcase
            end
            T3: begin
                G_Out  = 1'b1;
                Reg_Ld = rx_sel;
            end
            default: ;
        endcase
    end

    assign Ir     = ir_q;
    assign Time   = time_q;
    assign Done   = done_q;
    assign Alu_Op = alu_op;

endmodule
